om_port_arbiter: RTL
====================

Name: om_port_arbiter

Overview:
- Shares the single port of the object-map RAM (100 cells × 11 bit, 1-cycle read latency) between two requesters.
- Requester A is the game-logic updater, which reads and writes. Requester B is the entities drawer, which only reads.
- Provides a registered req/gnt handshake, round-robin arbitration, bounded grant hold under contention, and read-data return tagged to the issuing requester.
- Sits between the object-map RAM and its two clients.

Parameters:
- ADDR_W, 7, object-map address width.
- DATA_W, 11, object-map word width.
- MAX_HOLD, 16, maximum grant cycles while the other requester is waiting (range 1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- a_req  in  1  game-logic requests the port; held for the whole burst.
- a_addr  in  ADDR_W  game-logic cell address.
- a_we  in  1  write strobe for the current a_addr.
- a_wdata  in  DATA_W  write data.
- a_gnt  out  1  A owns the port.
- a_rvalid  out  1  a_rdata valid for A's read issued the previous cycle.
- a_rdata  out  DATA_W  read data to A.
- b_req  in  1  drawer requests the port.
- b_addr  in  ADDR_W  drawer cell address.
- b_gnt  out  1  B owns the port.
- b_rvalid  out  1  b_rdata valid for B's read issued the previous cycle.
- b_rdata  out  DATA_W  read data to B.
- ram_addr  out  ADDR_W  RAM address.
- ram_we  out  1  RAM write enable.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data, valid one cycle after the address.
- stat_preempt  out  16  preemption count (see Optional Feature).

Behaviour:
- Reset values:
  - a_gnt=0, b_gnt=0, a_rvalid=0, b_rvalid=0, stat_preempt=0.
  - Hold counter=0, last_owner=B, state=IDLE.
  - ram_we=0 and ram_addr=0 while idle.
- Reset asserted mid-burst drops both grants immediately. Any in-flight rvalid is lost.
- States:
  - IDLE: no grant.
  - OWN_A, OWN_B: grant held.
  - SWITCH: one dead cycle, no grant.
- Grant latency: gnt rises one cycle after req is sampled high in IDLE. The first access occurs in the first cycle gnt is high.
- IDLE arbitration:
  - Only one requester high: that requester wins.
  - Both high: the requester that is not last_owner wins. After reset A wins first.
- OWN_x transitions:
  - req_x low → IDLE next cycle. gnt falls one cycle after req falls.
  - The other requester pending while hold counter == MAX_HOLD−1 → preempt. Go to SWITCH, set last_owner=x.
- OWN_x hold counter:
  - Increments each cycle the other requester is high.
  - Is cleared when the other requester is low and on every state change.
- SWITCH → OWN_other. The preempted requester keeps req high and is regranted by normal arbitration later.
- A grant lasts at most MAX_HOLD cycles under contention. Without contention a grant is unlimited.
- Port mux, combinational from registered state:
  - OWN_A: ram_addr=a_addr, ram_wdata=a_wdata, ram_we=a_we & a_req.
  - OWN_B: ram_addr=b_addr, ram_we=0.
  - IDLE/SWITCH: ram_we=0.
- Access qualification:
  - An access counts only when gnt & req are both high. A cycle where gnt is high and req is already low performs no write and returns no rvalid.
- Read return:
  - a_rvalid is registered: it pulses one cycle after an OWN_A cycle with a_req=1 and a_we=0.
  - b_rvalid pulses one cycle after an OWN_B cycle with b_req=1.
  - Both rdata outputs are driven directly from ram_rdata. Data is valid only while the matching rvalid is high.
  - A read issued in the last grant cycle still returns its rvalid while gnt is low.
- At most one rvalid per cycle. a_rvalid and b_rvalid are never both high.
- Addresses ≥100 are passed through unchanged; range checking is the requester's job.

Optional Feature:
- Macro OM_ARB_STATS_EN.
- Defined: stat_preempt increments on each OWN→SWITCH transition, saturates at 16'hFFFF, and is cleared only by rst_n.
- Undefined: stat_preempt is tied to 0 and the counter logic is not built.

Test Plan:
- Reset, then a_req=1 alone at cycle 0 → a_gnt=1 at cycle 1. a_we=1, a_addr=7, a_wdata=11'h2A5 in cycle 1 → ram_we=1, ram_addr=7. b_gnt stays 0.
- a_req and b_req rise in the same cycle after reset → A granted first. A drops req after 3 cycles → IDLE → b_gnt rises. The next simultaneous request goes to A (last_owner=B).
- B reads addresses 0..99 continuously with a_req held high, MAX_HOLD=16 → b_gnt high for exactly 16 cycles, one SWITCH cycle, then a_gnt=1. stat_preempt=1 when OM_ARB_STATS_EN is defined, 0 otherwise.
- B reads address 99 in the last grant cycle, RAM returns 11'h5C3 → b_rvalid=1 and b_rdata=11'h5C3 one cycle later while b_gnt=0. a_rvalid stays 0.
- A write to address 12 followed by a read of 12 in the next cycle → a_rvalid next cycle with the written value. A write cycle produces no a_rvalid.
- rst_n pulled low during OWN_A with a_we=1 → a_gnt and ram_we go to 0 immediately (asynchronous). After release, last_owner=B and the arbiter is in IDLE.

Source files
------------

// File: rtl/om_port_arbiter.sv
// -----------------------------------------------------------------------------
// om_port_arbiter
//
// Shares the single port of the object-map RAM (100 x 11 bit, 1-cycle read
// latency) between the game-logic updater (A, read/write) and the entities
// drawer (B, read-only). Grants are registered and arbitrated round-robin.
// Under contention a grant is held for at most MAX_HOLD cycles, followed by
// one dead SWITCH cycle before the waiting requester takes over. Read data is
// returned to whichever requester issued the read.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   a_req/a_addr/a_we/a_wdata   requester A access request and write data
//   a_gnt/a_rvalid/a_rdata      A grant and read return
//   b_req/b_addr                requester B read request
//   b_gnt/b_rvalid/b_rdata      B grant and read return
//   ram_addr/ram_we/ram_wdata   RAM port, muxed from the current owner
//   ram_rdata                   RAM read data, one cycle after the address
//   stat_preempt                count of preemptions (optional statistics)
//
// Optional feature: define OM_ARB_STATS_EN to build the saturating
// preemption counter; otherwise stat_preempt is tied to zero.
// -----------------------------------------------------------------------------
module om_port_arbiter #(
   parameter int ADDR_W   = 7,
   parameter int DATA_W   = 11,
   parameter int MAX_HOLD = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic              a_we,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic [ADDR_W-1:0] b_addr,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic [15:0]       stat_preempt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      OWN_A  = 2'd1,
      OWN_B  = 2'd2,
      SWITCH = 2'd3
   } state_e;

   // Preemption fires on the last allowed contended cycle.
   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_e      state_q, state_d;
   logic        lastOwnerB_q, lastOwnerB_d;
   logic [7:0]  holdCnt_q, holdCnt_d;
   logic        aRvalid_q, aRvalid_d;
   logic        bRvalid_q, bRvalid_d;

   // State, round-robin pointer, hold counter and read-return flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         lastOwnerB_q <= 1'b1;
         holdCnt_q    <= 8'd0;
         aRvalid_q    <= 1'b0;
         bRvalid_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         lastOwnerB_q <= lastOwnerB_d;
         holdCnt_q    <= holdCnt_d;
         aRvalid_q    <= aRvalid_d;
         bRvalid_q    <= bRvalid_d;
      end
   end

   // Next-state logic. The hold counter defaults to zero, which covers
   // both "other requester idle" and every state change; it only advances
   // while staying in OWN_x with the other side waiting. lastOwnerB tracks
   // whoever was granted most recently, so SWITCH hands over to the other.
   always_comb begin
      state_d      = state_q;
      lastOwnerB_d = lastOwnerB_q;
      holdCnt_d    = 8'd0;
      case (state_q)
         IDLE: begin
            if (a_req && b_req) begin
               if (lastOwnerB_q) begin
                  state_d      = OWN_A;
                  lastOwnerB_d = 1'b0;
               end else begin
                  state_d      = OWN_B;
                  lastOwnerB_d = 1'b1;
               end
            end else if (a_req) begin
               state_d      = OWN_A;
               lastOwnerB_d = 1'b0;
            end else if (b_req) begin
               state_d      = OWN_B;
               lastOwnerB_d = 1'b1;
            end
         end
         OWN_A: begin
            if (!a_req) begin
               state_d = IDLE;
            end else if (b_req) begin
               if (holdCnt_q == HOLD_LAST) begin
                  state_d      = SWITCH;
                  lastOwnerB_d = 1'b0;
               end else begin
                  holdCnt_d = holdCnt_q + 8'd1;
               end
            end
         end
         OWN_B: begin
            if (!b_req) begin
               state_d = IDLE;
            end else if (a_req) begin
               if (holdCnt_q == HOLD_LAST) begin
                  state_d      = SWITCH;
                  lastOwnerB_d = 1'b1;
               end else begin
                  holdCnt_d = holdCnt_q + 8'd1;
               end
            end
         end
         SWITCH: begin
            if (lastOwnerB_q) begin
               state_d      = OWN_A;
               lastOwnerB_d = 1'b0;
            end else begin
               state_d      = OWN_B;
               lastOwnerB_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // A read is only issued when the owner also still requests; a grant
   // cycle with req already low returns nothing.
   always_comb begin
      aRvalid_d = (state_q == OWN_A) && a_req && !a_we;
      bRvalid_d = (state_q == OWN_B) && b_req;
   end

   // RAM port mux, driven purely from the registered owner.
   always_comb begin
      ram_addr  = '0;
      ram_we    = 1'b0;
      ram_wdata = '0;
      case (state_q)
         OWN_A: begin
            ram_addr  = a_addr;
            ram_wdata = a_wdata;
            ram_we    = a_we & a_req;
         end
         OWN_B: begin
            ram_addr = b_addr;
         end
         default: ;
      endcase
   end

   assign a_gnt    = (state_q == OWN_A);
   assign b_gnt    = (state_q == OWN_B);
   assign a_rvalid = aRvalid_q;
   assign b_rvalid = bRvalid_q;
   assign a_rdata  = ram_rdata;
   assign b_rdata  = ram_rdata;

`ifdef OM_ARB_STATS_EN
   logic        preempt;
   logic [15:0] statPreempt_q, statPreempt_d;

   // SWITCH is only ever entered from an OWN state by preemption.
   assign preempt = (state_q != SWITCH) && (state_d == SWITCH);

   always_comb begin
      statPreempt_d = statPreempt_q;
      if (preempt && (statPreempt_q != 16'hFFFF)) begin
         statPreempt_d = statPreempt_q + 16'd1;
      end
   end

   // Saturating preemption counter, cleared only by reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         statPreempt_q <= 16'd0;
      end else begin
         statPreempt_q <= statPreempt_d;
      end
   end

   assign stat_preempt = statPreempt_q;
`else
   assign stat_preempt = 16'd0;
`endif

endmodule
